ntt_radix_ct_bfly_arb: RTL
==========================

// Module: ntt_radix_ct_bfly_arb
// PURPOSE
//  Shares one ntt_radix_ct_mult_butterfly instance (no backpressure, fixed latency) between two
//  requesters (rq0, rq1) streaming R-coefficient beats plus R-1 twiddles. A round-robin arbiter
//  locks on bursts delimited by *_last. Per-requester credit counters guard each output buffer.
//  A 2-bit side tag {last,rid} routes butterfly results back to the originating requester.
// PARAMETERS
//  R        8   butterfly radix, power of 2
//  OP_W     32  coefficient width
//  LAT      8   butterfly in_avail->out_avail latency in cycles, >=1
//  CRED_NB  16  output-buffer slots per requester, >=1
// PORTS
//  clk            in   1             clock
//  s_rst_n        in   1             asynchronous active-low reset
//  rqN_vld        in   1             N=0,1: beat valid
//  rqN_rdy        out  1             beat accepted when vld&rdy
//  rqN_x          in   R*OP_W        coefficients
//  rqN_omg        in   (R-1)*OP_W    twiddles, index 1..R-1
//  rqN_last       in   1             last beat of burst; releases the lock
//  rsN_avail      out  1             result beat for requester N
//  rsN_x          out  R*OP_W        result coefficients
//  rsN_last       out  1             echo of the issued rqN_last
//  rsN_cred_ret   in   1             pulse: one output slot of N freed
//  bfly_in_x/omg/avail/side  out  R*OP_W/(R-1)*OP_W/R/2   drive to butterfly (avail replicated)
//  bfly_out_x/avail/side     in   R*OP_W/R/2              results from butterfly
//  busy           out  1             in-flight count !=0 or lock held
//  err            out  1             sticky: out_avail pattern mismatch or credit overflow
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr_ptr=0; credN=CRED_NB; inflight=0; err=0.
//  FSM: IDLE -> LOCK0 or LOCK1 on the first accepted non-last beat; LOCKn -> IDLE on accept of rqn_last.
//   - IDLE choice: both vld & eligible -> grant rr_ptr. Otherwise grant the single eligible one.
//   - Eligible means credN!=0.
//   - A beat with last=1 accepted in IDLE stays in IDLE (single-beat burst).
//   - rr_ptr toggles to the other requester on every accepted last beat.
//  rqN_rdy is combinational, equal to (grant==N)&(credN!=0). LOCKn never grants the other requester.
//  If credn hits 0 in LOCKn, the block stalls and stays locked.
//  Issue (accept cycle): register x, omg, side={last,N}; bfly_in_avail={R{1}} exactly 1 cycle later.
//  Otherwise bfly_in_avail=0, and data/side hold their last values.
//  Return: when bfly_out_avail[0], route to rs[side[0]]: rsN_avail=1, rsN_x, rsN_last=side[1].
//  Return is registered, so total latency = accept -> rsN_avail is LAT+2 cycles.
//  credN: -1 on issue of N, +1 on rsN_cred_ret; both in the same cycle -> unchanged.
//  cred_ret with credN==CRED_NB -> ignored, err set.
//  inflight: +1 on issue, -1 on bfly_out_avail[0]; range 0..LAT.
//  Checker: an LAT-deep shift register of issue pulses.
//   - bfly_out_avail[0] != shreg tail -> err set (sticky until reset).
//   - bfly_out_avail bits not all equal -> err set.
//  Back-to-back issue at 1 beat/cycle is sustained with no bubbles between beats or bursts.
//   - Handover IDLE->grant happens in the same cycle.
//  Reset mid-operation: in-flight results are dropped.
//   - Any butterfly outputs arriving after reset deassertion are ignored for LAT+1 cycles
//     (shreg cleared), with no err.
//  Widths: credN is $clog2(CRED_NB+1) bits; inflight is $clog2(LAT+1) bits.
// TESTING
//  1. Single-beat burst from rq0 -> rs0_avail at cycle LAT+2, rs0_last=1, cred0=15, then 16 after a cred_ret pulse.
//  2. rq0 burst of 4 and rq1 burst of 4, both always valid -> 0,0,0,0,1,1,1,1,0... and no idle cycle.
//  3. CRED_NB=16, rq0 sends 20 beats with no cred_ret:
//     - rq0_rdy drops after 16 beats and rq1 stays blocked (lock held).
//     - 4 cred_ret pulses release it.
//  4. Simultaneous issue and cred_ret each cycle for 100 cycles -> credN stays constant, err=0.
//  5. Model returns avail at LAT+1 instead of LAT -> err=1 one cycle after the mismatch, held until reset.
//  6. Assert s_rst_n with 5 beats in flight -> outputs 0 and cred=16.
//     - No rs*_avail after release, and err=0.

Source files
------------

// File: rtl/ntt_radix_ct_bfly_arb_if.sv
// Requester-side bundle: beat handshake in, result beats and credit returns.
// One instance per requester; the arbiter takes the slave view.
interface ntt_radix_ct_bfly_arb_if #(
   parameter int R    = 8,
   parameter int OP_W = 32
);
   logic                  vld;
   logic                  rdy;
   logic [R*OP_W-1:0]     x;
   logic [(R-1)*OP_W-1:0] omg;
   logic                  last;
   logic                  rs_avail;
   logic [R*OP_W-1:0]     rs_x;
   logic                  rs_last;
   logic                  cred_ret;

   modport master (
      output vld, x, omg, last, cred_ret,
      input  rdy, rs_avail, rs_x, rs_last
   );

   modport slave (
      input  vld, x, omg, last, cred_ret,
      output rdy, rs_avail, rs_x, rs_last
   );
endinterface

// File: rtl/ntt_radix_ct_bfly_arb.sv
// Two-requester burst-locking arbiter in front of one fixed-latency NTT butterfly,
// with per-requester output credits and a latency checker on the return path.
module ntt_radix_ct_bfly_arb #(
   parameter int R       = 8,
   parameter int OP_W    = 32,
   parameter int LAT     = 8,
   parameter int CRED_NB = 16
) (
   input  logic                  clk,
   input  logic                  s_rst_n,
   ntt_radix_ct_bfly_arb_if.slave rq0,
   ntt_radix_ct_bfly_arb_if.slave rq1,
   output logic [R*OP_W-1:0]     bfly_in_x,
   output logic [(R-1)*OP_W-1:0] bfly_in_omg,
   output logic [R-1:0]          bfly_in_avail,
   output logic [1:0]            bfly_in_side,
   input  logic [R*OP_W-1:0]     bfly_out_x,
   input  logic [R-1:0]          bfly_out_avail,
   input  logic [1:0]            bfly_out_side,
   output logic                  busy,
   output logic                  err
);
   localparam int XW = R * OP_W;
   localparam int WW = (R - 1) * OP_W;
   localparam int CW = $clog2(CRED_NB + 1);
   localparam int IW = $clog2(LAT + 1);
   localparam int BW = $clog2(LAT + 2);
   localparam logic [CW-1:0] CMAX = CW'(CRED_NB);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

   state_e          state_q, state_d;
   logic            rr_q, rr_d;
   logic [CW-1:0]   cred_q [2];
   logic [CW-1:0]   cred_d [2];
   logic [IW-1:0]   infl_q, infl_d;
   logic [LAT-1:0]  shreg_q, shreg_d;
   logic [BW-1:0]   blank_q, blank_d;
   logic            err_q, err_d;
   logic            iss_q, iss_d;
   logic [XW-1:0]   x_q, x_d;
   logic [WW-1:0]   omg_q, omg_d;
   logic [1:0]      side_q, side_d;
   logic [1:0]      rs_av_q, rs_av_d;
   logic [1:0]      rs_last_q, rs_last_d;
   logic [XW-1:0]   rs_x_q [2];
   logic [XW-1:0]   rs_x_d [2];

   logic [1:0] vld, elig, rdy, ret, ovf;
   logic       gnt_v, gnt, acc, acc_last;
   logic       tail, chk, use_out, bad, dec, inc;

   always_comb begin
      vld      = {rq1.vld, rq0.vld};
      ret      = {rq1.cred_ret, rq0.cred_ret};
      elig     = {cred_q[1] != '0, cred_q[0] != '0};
      gnt_v    = 1'b0;
      gnt      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (vld[0] && elig[0] && vld[1] && elig[1]) begin
               gnt_v = 1'b1;
               gnt   = rr_q;
            end else if (vld[0] && elig[0]) begin
               gnt_v = 1'b1;
            end else if (vld[1] && elig[1]) begin
               gnt_v = 1'b1;
               gnt   = 1'b1;
            end
         end
         LOCK0: gnt_v = elig[0];
         LOCK1: begin
            gnt_v = elig[1];
            gnt   = 1'b1;
         end
         default: ;
      endcase
      rdy      = {gnt_v & gnt, gnt_v & ~gnt};
      acc      = |(rdy & vld);
      acc_last = gnt ? rq1.last : rq0.last;

      state_d = state_q;
      rr_d    = rr_q;
      if (acc) begin
         if (acc_last) begin
            state_d = IDLE;
            rr_d    = ~gnt;
         end else begin
            state_d = gnt ? LOCK1 : LOCK0;
         end
      end

      iss_d  = acc;
      x_d    = acc ? (gnt ? rq1.x : rq0.x) : x_q;
      omg_d  = acc ? (gnt ? rq1.omg : rq0.omg) : omg_q;
      side_d = acc ? {acc_last, gnt} : side_q;

      ovf = '0;
      for (int n = 0; n < 2; n++) begin
         dec       = acc && (gnt == 1'(n));
         inc       = ret[n];
         cred_d[n] = cred_q[n];
         ovf[n]    = inc && !dec && (cred_q[n] == CMAX);
         if (dec && !inc)
            cred_d[n] = cred_q[n] - CW'(1);
         else if (inc && !dec && !ovf[n])
            cred_d[n] = cred_q[n] + CW'(1);
      end

      // After reset, only returns the shreg predicts are trusted until
      // the pre-reset contents of the butterfly pipe have drained.
      tail    = shreg_q[LAT-1];
      shreg_d = (shreg_q << 1) | LAT'(iss_q);
      blank_d = (blank_q != '0) ? blank_q - BW'(1) : blank_q;
      chk     = (blank_q == '0) || tail;
      use_out = chk && bfly_out_avail[0];
      bad     = chk && ((bfly_out_avail[0] != tail) ||
                (bfly_out_avail != {R{bfly_out_avail[0]}}));
      err_d   = err_q | ovf[0] | ovf[1] | bad;
      infl_d  = infl_q + IW'(iss_q) - IW'(use_out);

      rs_av_d   = '0;
      rs_last_d = rs_last_q;
      for (int n = 0; n < 2; n++) begin
         rs_x_d[n] = rs_x_q[n];
         if (use_out && (bfly_out_side[0] == 1'(n))) begin
            rs_av_d[n]   = 1'b1;
            rs_x_d[n]    = bfly_out_x;
            rs_last_d[n] = bfly_out_side[1];
         end
      end
   end

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q   <= IDLE;
         rr_q      <= 1'b0;
         cred_q[0] <= CMAX;
         cred_q[1] <= CMAX;
         infl_q    <= '0;
         shreg_q   <= '0;
         blank_q   <= BW'(LAT + 1);
         err_q     <= 1'b0;
         iss_q     <= 1'b0;
         x_q       <= '0;
         omg_q     <= '0;
         side_q    <= '0;
         rs_av_q   <= '0;
         rs_last_q <= '0;
         rs_x_q[0] <= '0;
         rs_x_q[1] <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         cred_q[0] <= cred_d[0];
         cred_q[1] <= cred_d[1];
         infl_q    <= infl_d;
         shreg_q   <= shreg_d;
         blank_q   <= blank_d;
         err_q     <= err_d;
         iss_q     <= iss_d;
         x_q       <= x_d;
         omg_q     <= omg_d;
         side_q    <= side_d;
         rs_av_q   <= rs_av_d;
         rs_last_q <= rs_last_d;
         rs_x_q[0] <= rs_x_d[0];
         rs_x_q[1] <= rs_x_d[1];
      end
   end

   assign rq0.rdy      = rdy[0];
   assign rq1.rdy      = rdy[1];
   assign rq0.rs_avail = rs_av_q[0];
   assign rq1.rs_avail = rs_av_q[1];
   assign rq0.rs_x     = rs_x_q[0];
   assign rq1.rs_x     = rs_x_q[1];
   assign rq0.rs_last  = rs_last_q[0];
   assign rq1.rs_last  = rs_last_q[1];

   assign bfly_in_x     = x_q;
   assign bfly_in_omg   = omg_q;
   assign bfly_in_side  = side_q;
   assign bfly_in_avail = {R{iss_q}};
   assign busy          = (infl_q != '0) || (state_q != IDLE) || iss_q;
   assign err           = err_q;
endmodule
